// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-edge frame, ACK check, timeout.
// Define PS2_TX_RESEND_EN to retry a NAKed or timed-out byte once before reporting failure.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       RSTN,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       ack_ok,
    output logic       error,
    output logic       busy,
    output logic       rx_inhibit,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          clk_oe_d, data_oe_d, ack_d, done_d, error_d;
    logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2;
    logic          fe, watching;
`ifdef PS2_TX_RESEND_EN
    logic [8:0]    frame_q, frame_d;
    logic          retry_q, retry_d;
`endif

    // Lines idle high, so synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_i;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_i;
            data_s2  <= data_s1;
        end
    end

    assign fe       = clk_prev & ~clk_s2;
    assign watching = (state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        inh_d     = inh_q;
        tmo_d     = tmo_q;
        clk_oe_d  = ps2_clk_oe;
        data_oe_d = ps2_data_oe;
        ack_d     = ack_ok;
        done_d    = 1'b0;
        error_d   = 1'b0;
`ifdef PS2_TX_RESEND_EN
        frame_d   = frame_q;
        retry_d   = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shift_d  = {~^tx_data, tx_data};
                    inh_d    = '0;
                    tmo_d    = '0;
                    bitcnt_d = '0;
                    ack_d    = 1'b0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
`ifdef PS2_TX_RESEND_EN
                    frame_d  = {~^tx_data, tx_data};
                    retry_d  = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                inh_d = inh_q + IW'(1);
                if (inh_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                clk_oe_d = 1'b0;
                bitcnt_d = '0;
                tmo_d    = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                tmo_d = tmo_q + TW'(1);
                if (fe) begin
                    tmo_d = '0;
                    if (bitcnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        bitcnt_d  = bitcnt_q + 4'd1;
                    end
                end
            end
            S_ACK: begin
                tmo_d = tmo_q + TW'(1);
                if (fe) begin
                    tmo_d   = '0;
                    ack_d   = ~data_s2;
                    state_d = S_WAIT_IDLE;
`ifdef PS2_TX_RESEND_EN
                    if (data_s2 && !retry_q) begin
                        retry_d  = 1'b1;
                        shift_d  = frame_q;
                        inh_d    = '0;
                        bitcnt_d = '0;
                        clk_oe_d = 1'b1;
                        state_d  = S_INHIBIT;
                    end
`endif
                end
            end
            S_WAIT_IDLE: begin
                tmo_d = tmo_q + TW'(1);
                if (clk_s2 && data_s2) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled device overrides whatever the frame logic wanted.
        if (watching && tmo_q == TMO_LAST) begin
`ifdef PS2_TX_RESEND_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                shift_d   = frame_q;
                inh_d     = '0;
                bitcnt_d  = '0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                done_d    = 1'b0;
                state_d   = S_INHIBIT;
            end else begin
`else
            begin
`endif
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                ack_d     = 1'b0;
                done_d    = 1'b1;
                error_d   = 1'b1;
                state_d   = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            inh_q       <= '0;
            tmo_q       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            ack_ok      <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            frame_q     <= '0;
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            inh_q       <= inh_d;
            tmo_q       <= tmo_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            ack_ok      <= ack_d;
            done        <= done_d;
            error       <= error_d;
`ifdef PS2_TX_RESEND_EN
            frame_q     <= frame_d;
            retry_q     <= retry_d;
`endif
        end
    end

    assign tx_ready   = (state_q == S_IDLE);
    assign busy       = ~tx_ready;
    assign rx_inhibit = busy;
endmodule
